// File: rtl/turn_seq_pkg.sv
// Shared definitions for the tail-light turn/hazard sequencer:
// driver-mode encoding and the thermometer mask used by the lamp sweep.
package turn_seq_pkg;

    // Raw encodings of the D input as the driver-control decode delivers them.
    localparam logic [1:0] D_OFF    = 2'b00;
    localparam logic [1:0] D_RIGHT  = 2'b01;
    localparam logic [1:0] D_LEFT   = 2'b10;
    localparam logic [1:0] D_HAZARD = 2'b11;

    // Same encodings as an enum so the stored mode reads clearly in case statements.
    typedef enum logic [1:0] {
        MODE_OFF    = D_OFF,
        MODE_RIGHT  = D_RIGHT,
        MODE_LEFT   = D_LEFT,
        MODE_HAZARD = D_HAZARD
    } mode_e;

    // Widest lamp bank the mask helper supports; callers size-cast the result
    // down to their own N_LAMPS.
    localparam int unsigned MAX_LAMPS = 32;

    // Thermometer mask with the k least-significant bits set (k innermost lamps).
    function automatic logic [MAX_LAMPS-1:0] therm_mask(input int unsigned k);
        logic [MAX_LAMPS-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MAX_LAMPS; i++) begin
            mask[i] = (i < k);
        end
        return mask;
    endfunction

endpackage

// File: rtl/turn_seq_param_step_prescaler.sv
// Animation step prescaler: divides the clock so the lamp sweep advances
// once every TICK_DIV enabled cycles.
module step_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Tick fires on the last count of each enabled window; clr wins over en.
    assign tick = en && !clr && (cnt_q == CNT_LAST);

    // Next-count logic: restart on clear, wrap on the last count, hold when idle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Count register, cleared asynchronously by reset.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: asynchronous reset clears state without a clock; flops use <= so all
        // registers update together from the pre-edge values.
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/turn_seq_param.sv
// Parametrised tail-light turn/hazard sequencer. Holds the sampled driver mode,
// steps the sweep phase on prescaler ticks, and maps mode/phase/brake onto
// registered left and right lamp banks.
module turn_seq_param
    import turn_seq_pkg::*;
#(
    parameter int N_LAMPS     = 3,
    parameter int TICK_DIV    = 1,
    parameter int BLANK_PHASE = 0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [1:0]         D,
    input  logic               BRAKE,
    output logic [N_LAMPS-1:0] L,
    output logic [N_LAMPS-1:0] R,
    output logic               active
);

    // Turn modes run 1..N_LAMPS, plus one trailing blank step when enabled.
    localparam int LAST_PHASE = N_LAMPS + ((BLANK_PHASE != 0) ? 1 : 0);
    localparam int PH_W       = $clog2(LAST_PHASE + 1);

    localparam logic [PH_W-1:0] PH_ZERO = '0;
    localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
    localparam logic [PH_W-1:0] PH_FULL = PH_W'(N_LAMPS);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(LAST_PHASE);

    mode_e              mode_q, mode_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [N_LAMPS-1:0] lamp_l_q, lamp_l_d;
    logic [N_LAMPS-1:0] lamp_r_q, lamp_r_d;
    logic               active_q, active_d;

    logic               mode_change;
    logic               presc_clr;
    logic               tick;
    logic [N_LAMPS-1:0] sweep;

    assign mode_change = (D != mode_q);

    // The prescaler restarts on any mode change and is held at zero while off.
    assign presc_clr = mode_change || (mode_q == MODE_OFF);

    step_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (presc_clr),
        .en   (!presc_clr),
        .tick (tick)
    );

    // Mode and phase next-state: a new mode restarts at phase 1 (0 for off),
    // otherwise the phase advances on each prescaler tick.
    always_comb begin
        mode_d  = mode_q;
        phase_d = phase_q;
        if (mode_change) begin
            mode_d  = mode_e'(D);
            phase_d = (D == D_OFF) ? PH_ZERO : PH_ONE;
        end else if (mode_q == MODE_OFF) begin
            phase_d = PH_ZERO;
        end else if (tick) begin
            if (mode_q == MODE_HAZARD) begin
                phase_d = (phase_q == PH_ONE) ? PH_ZERO : PH_ONE;
            end else begin
                phase_d = (phase_q >= PH_LAST) ? PH_ONE : phase_q + PH_ONE;
            end
        end
    end

    // Output mapping from the next mode/phase so lamps follow D and BRAKE one
    // cycle later; phases outside 1..N_LAMPS (blank or unreachable) stay dark.
    always_comb begin
        sweep    = '0;
        lamp_l_d = '0;
        lamp_r_d = '0;
        active_d = (mode_d != MODE_OFF);
        if ((phase_d != PH_ZERO) && (phase_d <= PH_FULL)) begin
            sweep = N_LAMPS'(therm_mask(32'(phase_d)));
        end
        case (mode_d)
            MODE_RIGHT: begin
                lamp_r_d = sweep;
                lamp_l_d = BRAKE ? '1 : '0;
            end
            MODE_LEFT: begin
                lamp_l_d = sweep;
                lamp_r_d = BRAKE ? '1 : '0;
            end
            MODE_HAZARD: begin
                lamp_l_d = (phase_d == PH_ONE) ? '1 : '0;
                lamp_r_d = (phase_d == PH_ONE) ? '1 : '0;
            end
            default: begin
                lamp_l_d = BRAKE ? '1 : '0;
                lamp_r_d = BRAKE ? '1 : '0;
            end
        endcase
    end

    // State and registered outputs; reset gives dark lamps and the off mode.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_q   <= MODE_OFF;
            phase_q  <= PH_ZERO;
            lamp_l_q <= '0;
            lamp_r_q <= '0;
            active_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            phase_q  <= phase_d;
            lamp_l_q <= lamp_l_d;
            lamp_r_q <= lamp_r_d;
            active_q <= active_d;
        end
    end

    assign L      = lamp_l_q;
    assign R      = lamp_r_q;
    assign active = active_q;

endmodule
